fetch_unit: RTL and testbench

- Instruction-fetch stage; producer side of the Fetch→Decode pipeline register.
- Owns the PC and issues word requests to instruction memory (variable latency, one request in flight).
- Presents InstrF/PCF/PCPlus4F plus a valid flag, holds them stable under stall, and accepts PC redirects from Execute.

---
 rtl/riscv_pipe_pkg.sv | 18 +
 rtl/fetch_hold_buf.sv | 71 +++++++
 rtl/fetch_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: types and constants shared by the pipeline stages.
//   XLEN           - datapath width
//   NOP_ADDI       - canonical bubble instruction (addi x0,x0,0)
//   fetch_state_e  - fetch sequencer states (HALT is only reachable when
//                    FETCH_MISALIGN_TRAP_EN is defined)
package riscv_pipe_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_ADDI = 32'h0000_0013;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: holding buffer between instruction fetch and the F/D
// register. Stores {instr, pc, pc+4} plus a valid flag and presents a bubble
// whenever the buffer is empty.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   load            - capture instr_in/pc_in/pcplus4_in, set valid
//   clear           - drop valid (wins over load)
//   instr_in, pc_in, pcplus4_in - data to capture
//   instr_out, pc_out, pcplus4_out - buffer contents or bubble
//   valid_out       - buffer holds a real instruction
import riscv_pipe_pkg::*;

module fetch_hold_buf #(
    parameter logic [XLEN-1:0] BUBBLE_INSTR = NOP_ADDI
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] pcplus4_in,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pcplus4_out,
    output logic            valid_out
);

    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pcplus4_q, pcplus4_d;
    logic            valid_q, valid_d;

    always_comb begin
        instr_d   = instr_q;
        pc_d      = pc_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            instr_d   = instr_in;
            pc_d      = pc_in;
            pcplus4_d = pcplus4_in;
            valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q   <= '0;
            pc_q      <= '0;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    // Stale contents are never shown: an empty buffer presents a bubble.
    always_comb begin
        valid_out   = valid_q;
        instr_out   = valid_q ? instr_q   : BUBBLE_INSTR;
        pc_out      = valid_q ? pc_q      : '0;
        pcplus4_out = valid_q ? pcplus4_q : '0;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage, producer side of the F/D register.
// Owns the PC, issues one word request at a time to instruction memory
// (variable latency), and holds the fetched instruction until decode takes it.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   stall_f             - decode not accepting; hold presented instruction
//   redirect, redirect_pc - PC redirect from Execute (highest priority)
//   imem_req, imem_addr - request strobe and word address
//   imem_rvalid, imem_rdata - memory response
//   InstrF, PCF, PCPlus4F, fetch_valid - presented instruction
//   fetch_misaligned    - sticky misaligned-redirect trap (only with
//                         FETCH_MISALIGN_TRAP_EN defined)
// Build option: define FETCH_MISALIGN_TRAP_EN to trap redirects whose target
// is not word aligned; the unit then halts until reset.
import riscv_pipe_pkg::*;

module fetch_unit #(
    parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
    parameter logic [XLEN-1:0] BUBBLE_INSTR = NOP_ADDI
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_f,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] InstrF,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] PCPlus4F,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic            fetch_misaligned,
`endif
    output logic            fetch_valid
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] pc_plus4;
    logic            redirect_act;
    logic            buf_load, buf_clear;

    assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned_q, misaligned_d;
    // Once halted, nothing but reset is honoured, including redirects.
    assign redirect_act     = redirect && (state_q != HALT);
    assign fetch_misaligned = misaligned_q;
`else
    assign redirect_act = redirect;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ISSUE;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) misaligned_q <= 1'b0;
        else     misaligned_q <= misaligned_d;
    end
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        misaligned_d = misaligned_q;
`endif
        case (state_q)
            ISSUE: state_d = WAIT;
            WAIT: begin
                // kill marks a response that belongs to a pre-redirect PC.
                if (imem_rvalid) begin
                    state_d = kill_q ? ISSUE : HOLD;
                    kill_d  = 1'b0;
                end
            end
            HOLD: begin
                if (!stall_f) begin
                    pc_d    = pc_plus4;
                    state_d = ISSUE;
                end
            end
            default: ;
        endcase

        if (redirect_act) begin
            pc_d = redirect_pc;
            case (state_q)
                ISSUE: begin
                    // This cycle's request is already out; its reply is stale.
                    kill_d  = 1'b1;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = ISSUE;
                    end else begin
                        kill_d  = 1'b1;
                        state_d = WAIT;
                    end
                end
                default: state_d = ISSUE;
            endcase
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) begin
                state_d      = HALT;
                kill_d       = 1'b0;
                misaligned_d = 1'b1;
            end
`endif
        end
    end

    // Output logic. imem_req is gated by rst so no request is shown while
    // reset holds the sequencer in ISSUE.
    always_comb begin
        imem_req  = (state_q == ISSUE) && !rst;
        imem_addr = pc_q;
        buf_load  = (state_q == WAIT) && imem_rvalid && !kill_q && !redirect_act;
        buf_clear = redirect_act || ((state_q == HOLD) && !stall_f);
    end

    fetch_hold_buf #(
        .BUBBLE_INSTR(BUBBLE_INSTR)
    ) u_hold_buf (
        .clk         (clk),
        .rst         (rst),
        .load        (buf_load),
        .clear       (buf_clear),
        .instr_in    (imem_rdata),
        .pc_in       (pc_q),
        .pcplus4_in  (pc_plus4),
        .instr_out   (InstrF),
        .pc_out      (PCF),
        .pcplus4_out (PCPlus4F),
        .valid_out   (fetch_valid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, table-driven bench for fetch_unit. Each table row
// drives one cycle of inputs and lists the outputs expected in that cycle
// (memory responses are hand-scheduled in the table).
module tb_fetch_unit;

    localparam logic [31:0] B = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_f, redirect, imem_rvalid;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, fetch_valid;
    logic [31:0] imem_addr, InstrF, PCF, PCPlus4F;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misaligned;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall_f     (stall_f),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .InstrF      (InstrF),
        .PCF         (PCF),
        .PCPlus4F    (PCPlus4F),
`ifdef FETCH_MISALIGN_TRAP_EN
        .fetch_misaligned (fetch_misaligned),
`endif
        .fetch_valid (fetch_valid)
    );

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_instr;
        logic [31:0] e_pcf;
        logic [31:0] e_pcp4;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic st, logic rd, logic [31:0] rpc, logic rv,
                                logic [31:0] rdat, logic req, logic [31:0] addr,
                                logic vld, logic [31:0] ins, logic [31:0] pcf,
                                logic [31:0] pcp4);
        vec_t v;
        v.stall = st; v.redir = rd; v.rpc = rpc; v.rv = rv; v.rdata = rdat;
        v.e_req = req; v.e_addr = addr; v.e_vld = vld; v.e_instr = ins;
        v.e_pcf = pcf; v.e_pcp4 = pcp4;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                         input logic rv, input logic [31:0] rdat);
        stall_f = st; redirect = rd; redirect_pc = rpc;
        imem_rvalid = rv; imem_rdata = rdat;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_vld"},   {31'd0, fetch_valid}, 32'd0);
        chk({tag, "_instr"}, InstrF, B);
        chk({tag, "_pcf"},   PCF, 32'd0);
        chk({tag, "_pcp4"},  PCPlus4F, 32'd0);
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // stall rd  rpc          rv rdata          req addr         vld instr          pcf          pcp4
        tbl.push_back(mk(0,0,0,0,0,                 1,32'h0,         0,B,0,0));
        tbl.push_back(mk(0,0,0,1,32'hAAAA_0000,     0,0,             0,B,0,0));
        tbl.push_back(mk(0,0,0,0,0,                 0,0,             1,32'hAAAA_0000,32'h0,32'h4));
        tbl.push_back(mk(0,0,0,0,0,                 1,32'h4,         0,B,0,0));
        tbl.push_back(mk(0,0,0,1,32'hAAAA_0004,     0,0,             0,B,0,0));
        tbl.push_back(mk(0,0,0,0,0,                 0,0,             1,32'hAAAA_0004,32'h4,32'h8));
        tbl.push_back(mk(0,0,0,0,0,                 1,32'h8,         0,B,0,0));
        tbl.push_back(mk(0,0,0,1,32'hAAAA_0008,     0,0,             0,B,0,0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1,0,0,0,0,             0,0,             1,32'hAAAA_0008,32'h8,32'hC));
        tbl.push_back(mk(0,0,0,0,0,                 0,0,             1,32'hAAAA_0008,32'h8,32'hC));
        tbl.push_back(mk(0,0,0,0,0,                 1,32'hC,         0,B,0,0));
        tbl.push_back(mk(0,0,0,1,32'hAAAA_000C,     0,0,             0,B,0,0));
        tbl.push_back(mk(0,0,0,0,0,                 0,0,             1,32'hAAAA_000C,32'hC,32'h10));
        tbl.push_back(mk(0,0,0,0,0,                 1,32'h10,        0,B,0,0));
        // redirect while 0x10 outstanding (3-cycle latency)
        tbl.push_back(mk(0,1,32'h100,0,0,           0,0,             0,B,0,0));
        tbl.push_back(mk(0,0,0,0,0,                 0,0,             0,B,0,0));
        tbl.push_back(mk(0,0,0,1,32'hAAAA_0010,     0,0,             0,B,0,0));
        tbl.push_back(mk(0,0,0,0,0,                 1,32'h100,       0,B,0,0));
        tbl.push_back(mk(0,0,0,1,32'hAAAA_0100,     0,0,             0,B,0,0));
        tbl.push_back(mk(0,0,0,0,0,                 0,0,             1,32'hAAAA_0100,32'h100,32'h104));
        // redirect in ISSUE: the request to 0x104 is killed
        tbl.push_back(mk(0,1,32'h20,0,0,            1,32'h104,       0,B,0,0));
        tbl.push_back(mk(0,0,0,1,32'hAAAA_0104,     0,0,             0,B,0,0));
        tbl.push_back(mk(0,0,0,0,0,                 1,32'h20,        0,B,0,0));
        tbl.push_back(mk(0,0,0,1,32'hAAAA_0020,     0,0,             0,B,0,0));
        // redirect with stall in HOLD
        tbl.push_back(mk(1,1,32'h40,0,0,            0,0,             1,32'hAAAA_0020,32'h20,32'h24));
        tbl.push_back(mk(1,0,0,0,0,                 1,32'h40,        0,B,0,0));
        // redirect with same-cycle rvalid
        tbl.push_back(mk(0,1,32'h80,1,32'hAAAA_0040,0,0,             0,B,0,0));
        tbl.push_back(mk(0,0,0,0,0,                 1,32'h80,        0,B,0,0));
        tbl.push_back(mk(0,0,0,1,32'hAAAA_0080,     0,0,             0,B,0,0));
        tbl.push_back(mk(0,0,0,0,0,                 0,0,             1,32'hAAAA_0080,32'h80,32'h84));
        // PC wrap at the top of the address space
        tbl.push_back(mk(0,1,32'hFFFF_FFFC,1,32'hDEAD_0000,1,32'h84, 0,B,0,0));
        tbl.push_back(mk(0,0,0,1,32'hAAAA_0084,     0,0,             0,B,0,0));
        tbl.push_back(mk(0,0,0,0,0,                 1,32'hFFFF_FFFC, 0,B,0,0));
        tbl.push_back(mk(0,0,0,1,32'h1234_5678,     0,0,             0,B,0,0));
        tbl.push_back(mk(0,0,0,0,0,                 0,0,             1,32'h1234_5678,32'hFFFF_FFFC,32'h0));
        tbl.push_back(mk(0,0,0,0,0,                 1,32'h0,         0,B,0,0));
        tbl.push_back(mk(0,0,0,0,0,                 0,0,             0,B,0,0));
        tbl.push_back(mk(0,0,0,1,32'h0000_0055,     0,0,             0,B,0,0));
        tbl.push_back(mk(0,0,0,0,0,                 0,0,             1,32'h0000_0055,32'h0,32'h4));
        // stray rvalid in ISSUE is ignored
        tbl.push_back(mk(0,0,0,1,32'h0000_0099,     1,32'h4,         0,B,0,0));
        tbl.push_back(mk(0,0,0,0,0,                 0,0,             0,B,0,0));
        tbl.push_back(mk(0,0,0,1,32'hAAAA_0004,     0,0,             0,B,0,0));
        tbl.push_back(mk(0,0,0,0,0,                 0,0,             1,32'hAAAA_0004,32'h4,32'h8));

        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_req", {31'd0, imem_req}, 32'd0);
        chk_bubble("reset");
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("reset_mis", {31'd0, fetch_misaligned}, 32'd0);
`endif
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].stall, tbl[i].redir, tbl[i].rpc, tbl[i].rv, tbl[i].rdata);
            #1;
            chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].e_req});
            if (tbl[i].e_req)
                chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("v%0d_vld", i), {31'd0, fetch_valid}, {31'd0, tbl[i].e_vld});
            chk($sformatf("v%0d_instr", i), InstrF, tbl[i].e_instr);
            chk($sformatf("v%0d_pcf", i), PCF, tbl[i].e_pcf);
            chk($sformatf("v%0d_pcp4", i), PCPlus4F, tbl[i].e_pcp4);
            step();
        end

        // Reset while a request to 0x8 is outstanding, then a late response.
        drive(0, 0, 0, 0, 0);
        chk("mid_issue", {31'd0, imem_req}, 32'd1);
        chk("mid_addr", imem_addr, 32'h8);
        step();
        rst = 1'b1;
        #1;
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk_bubble("mid_rst");
        step();
        rst = 1'b0;
        drive(0, 0, 0, 1, 32'hBAD0_0008);   // late response, nothing requested yet
        #1;
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        chk("post_rst_addr", imem_addr, 32'h0);
        step();
        drive(0, 0, 0, 0, 0);
        #1;
        chk_bubble("post_rst_wait");
        step();
        drive(0, 0, 0, 1, 32'hCAFE_0000);
        step();
        drive(0, 0, 0, 0, 0);
        #1;
        chk("post_rst_vld", {31'd0, fetch_valid}, 32'd1);
        chk("post_rst_instr", InstrF, 32'hCAFE_0000);
        chk("post_rst_pcf", PCF, 32'h0);

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned redirect from HOLD halts the unit until reset.
        drive(0, 1, 32'h102, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        #1;
        chk("mis_flag", {31'd0, fetch_misaligned}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            drive(0, k[0], 32'h200, 1, 32'h1111_1111);
            #1;
            chk($sformatf("halt%0d_req", k), {31'd0, imem_req}, 32'd0);
            chk($sformatf("halt%0d_vld", k), {31'd0, fetch_valid}, 32'd0);
            step();
        end
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mis_clr", {31'd0, fetch_misaligned}, 32'd0);
        chk("mis_req", {31'd0, imem_req}, 32'd1);
        chk("mis_addr", imem_addr, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
